// File: rtl/udp_cmd_pkg.sv
// Shared opcodes, parser state encoding and command-acceptance rule for the
// UDP control-datagram parser.
package udp_cmd_pkg;

    localparam logic [7:0]  OP_CAM     = 8'h01;
    localparam logic [7:0]  OP_WB      = 8'h02;
    localparam logic [7:0]  OP_DW      = 8'h03;
    localparam logic [7:0]  OP_SEND    = 8'h04;
    localparam logic [7:0]  OP_DIV     = 8'h05;
    localparam logic [7:0]  OP_DEFAULT = 8'h06;
    localparam logic [15:0] CMD_LEN    = 16'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_OP,
        ST_ARG,
        ST_CHK,
        ST_WAIT_END,
        ST_DROP
    } state_t;

    // A well-formed datagram still needs a known opcode; a zero divider would
    // stall the sender, so it is refused.
    function automatic logic cmd_accepted(input logic [7:0] op, input logic [7:0] arg);
        case (op)
            OP_CAM, OP_WB, OP_DW, OP_SEND, OP_DEFAULT: return 1'b1;
            OP_DIV:                                    return arg != 8'h00;
            default:                                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// 8-bit event counter; SATURATE=1 holds at 255, SATURATE=0 wraps to 0.
module sat_counter #(
    parameter bit SATURATE = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_inc,
    output logic [7:0] o_cnt
);

    logic [7:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_inc && !(SATURATE && r_cnt == 8'hFF))
            r_cnt <= r_cnt + 8'd1;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/udp_cmd_parser.sv
// Parses 4-byte control datagrams (MAGIC, opcode, arg, xor) from the UDP RX
// byte stream and commits accepted commands to registered config outputs.
module udp_cmd_parser
    import udp_cmd_pkg::*;
#(
    parameter logic [7:0] MAGIC        = 8'hA5,
    parameter logic       DEF_CAM      = 1'b0,
    parameter logic [7:0] DEF_SEND_DIV = 8'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic [15:0] rx_data_len,
    input  logic        rx_error,
    output logic        cfg_cam_sel,
    output logic        cfg_wb_en,
    output logic        cfg_dw_en,
    output logic        cfg_send_en,
    output logic [7:0]  cfg_send_div,
    output logic        cmd_ok,
    output logic [7:0]  cmd_op,
    output logic [7:0]  ok_cnt,
    output logic [7:0]  err_cnt
);

    state_t     r_state;
    state_t     w_cur;
    state_t     w_nxt;
    logic       w_commit;
    logic       w_reject;
    logic       r_armed;
    logic       r_bad;
    logic [7:0] r_xor;
    logic [7:0] r_op;
    logic [7:0] r_arg;

    logic       r_cam;
    logic       r_wb;
    logic       r_dw;
    logic       r_send;
    logic [7:0] r_div;
    logic       r_cmd_ok;
    logic [7:0] r_cmd_op;

    // Role of the current cycle: the first byte after idle is the header, but
    // a stream already running when reset releases is never parsed.
    always_comb begin
        w_cur = r_state;
        if (r_state == ST_IDLE && rx_valid)
            w_cur = r_armed ? ST_HDR : ST_DROP;
    end

    always_comb begin
        w_nxt    = w_cur;
        w_commit = 1'b0;
        w_reject = 1'b0;
        if (!rx_valid) begin
            w_nxt = ST_IDLE;
            if (r_state != ST_IDLE) begin
                if (r_state == ST_WAIT_END && !r_bad && !rx_error && cmd_accepted(r_op, r_arg))
                    w_commit = 1'b1;
                else
                    w_reject = 1'b1;
            end
        end else if (rx_error) begin
            w_nxt = (w_cur == ST_WAIT_END) ? ST_WAIT_END : ST_DROP;
        end else begin
            case (w_cur)
                ST_HDR:  w_nxt = (rx_data_len == CMD_LEN && rx_data == MAGIC) ? ST_OP : ST_DROP;
                ST_OP:   w_nxt = ST_ARG;
                ST_ARG:  w_nxt = ST_CHK;
                ST_CHK:  w_nxt = (rx_data == r_xor) ? ST_WAIT_END : ST_DROP;
                default: w_nxt = w_cur;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed <= 1'b0;
            r_bad   <= 1'b0;
            r_xor   <= '0;
            r_op    <= '0;
            r_arg   <= '0;
        end else begin
            if (!rx_valid)
                r_armed <= 1'b1;
            if (rx_valid) begin
                case (w_cur)
                    ST_HDR: begin
                        r_xor <= rx_data;
                        r_bad <= 1'b0;
                    end
                    ST_OP: begin
                        r_op  <= rx_data;
                        r_xor <= r_xor ^ rx_data;
                    end
                    ST_ARG: begin
                        r_arg <= rx_data;
                        r_xor <= r_xor ^ rx_data;
                    end
                    // Anything past the fourth byte spoils the datagram.
                    ST_WAIT_END: r_bad <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cam    <= DEF_CAM;
            r_wb     <= 1'b0;
            r_dw     <= 1'b0;
            r_send   <= 1'b0;
            r_div    <= DEF_SEND_DIV;
            r_cmd_ok <= 1'b0;
            r_cmd_op <= '0;
        end else begin
            r_cmd_ok <= w_commit;
            if (w_commit) begin
                r_cmd_op <= r_op;
                case (r_op)
                    OP_CAM:  r_cam  <= r_arg[0];
                    OP_WB:   r_wb   <= r_arg[0];
                    OP_DW:   r_dw   <= r_arg[0];
                    OP_SEND: r_send <= r_arg[0];
                    OP_DIV:  r_div  <= r_arg;
                    OP_DEFAULT: begin
                        r_cam  <= DEF_CAM;
                        r_wb   <= 1'b0;
                        r_dw   <= 1'b0;
                        r_send <= 1'b0;
                        r_div  <= DEF_SEND_DIV;
                    end
                    default: ;
                endcase
            end
        end
    end

    sat_counter #(.SATURATE(1'b0)) u_ok_cnt (
        .i_clk (clk),
        .i_rst (rst),
        .i_inc (w_commit),
        .o_cnt (ok_cnt)
    );

    sat_counter #(.SATURATE(1'b1)) u_err_cnt (
        .i_clk (clk),
        .i_rst (rst),
        .i_inc (w_reject),
        .o_cnt (err_cnt)
    );

    assign cfg_cam_sel  = r_cam;
    assign cfg_wb_en    = r_wb;
    assign cfg_dw_en    = r_dw;
    assign cfg_send_en  = r_send;
    assign cfg_send_div = r_div;
    assign cmd_ok       = r_cmd_ok;
    assign cmd_op       = r_cmd_op;

endmodule

// File: tb/tb_udp_cmd_parser.sv
// Scoreboard bench: stimulus pushes the expected post-datagram outputs, a
// negedge monitor compares them one cycle after each datagram end.
module tb_udp_cmd_parser;

    localparam logic [7:0] MAGIC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [15:0] rx_data_len;
    logic        rx_error;
    logic        cfg_cam_sel, cfg_wb_en, cfg_dw_en, cfg_send_en, cmd_ok;
    logic [7:0]  cfg_send_div, cmd_op, ok_cnt, err_cnt;

    always #4 clk = ~clk;

    udp_cmd_parser #(.MAGIC(MAGIC), .DEF_CAM(1'b0), .DEF_SEND_DIV(8'd1)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_data_len  (rx_data_len),
        .rx_error     (rx_error),
        .cfg_cam_sel  (cfg_cam_sel),
        .cfg_wb_en    (cfg_wb_en),
        .cfg_dw_en    (cfg_dw_en),
        .cfg_send_en  (cfg_send_en),
        .cfg_send_div (cfg_send_div),
        .cmd_ok       (cmd_ok),
        .cmd_op       (cmd_op),
        .ok_cnt       (ok_cnt),
        .err_cnt      (err_cnt)
    );

    typedef struct packed {
        logic       ok;
        logic       cam;
        logic       wb;
        logic       dw;
        logic       se;
        logic [7:0] div;
        logic [7:0] op;
        logic [7:0] okc;
        logic [7:0] errc;
    } obs_t;

    obs_t       exp_q[$];
    logic       m_cam, m_wb, m_dw, m_se;
    logic [7:0] m_div, m_op, m_okc, m_errc;
    logic [7:0] dg[8];
    bit         done = 1'b0;

    int   errors = 0;
    int   checks = 0;
    int   dg_idx = 0;
    bit   pend = 1'b0;
    bit   prev_v = 1'b0;
    obs_t mon_e, mon_a;

    // ---------------- reference model ----------------
    function automatic bit ref_good(input int n, input int len, input bit err);
        if (err || n != 4 || len != 4) return 1'b0;
        if (dg[0] != MAGIC) return 1'b0;
        if (dg[3] != (dg[0] ^ dg[1] ^ dg[2])) return 1'b0;
        if (dg[1] < 8'd1 || dg[1] > 8'd6) return 1'b0;
        if (dg[1] == 8'd5 && dg[2] == 8'd0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_cfg_defaults();
        m_cam = 1'b0; m_wb = 1'b0; m_dw = 1'b0; m_se = 1'b0; m_div = 8'd1;
    endtask

    task automatic model_reset();
        model_cfg_defaults();
        m_op = 8'd0; m_okc = 8'd0; m_errc = 8'd0;
    endtask

    task automatic model_end(input bit good);
        obs_t e;
        if (good) begin
            m_op  = dg[1];
            m_okc = m_okc + 8'd1;
            case (dg[1])
                8'd1: m_cam = dg[2][0];
                8'd2: m_wb  = dg[2][0];
                8'd3: m_dw  = dg[2][0];
                8'd4: m_se  = dg[2][0];
                8'd5: m_div = dg[2];
                default: model_cfg_defaults();
            endcase
        end else if (m_errc != 8'd255) begin
            m_errc = m_errc + 8'd1;
        end
        e.ok = good; e.cam = m_cam; e.wb = m_wb; e.dw = m_dw; e.se = m_se;
        e.div = m_div; e.op = m_op; e.okc = m_okc; e.errc = m_errc;
        exp_q.push_back(e);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk); #1;
            rx_valid = 1'b0; rx_data = 8'h00; rx_error = 1'b0;
        end
    endtask

    // Drives n bytes then the end cycle E, and leaves E driven on return so
    // the next call's first byte lands in E+1.
    task automatic send(input int n, input int len, input int err_at);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rx_valid = 1'b1; rx_data = dg[i]; rx_data_len = 16'(len); rx_error = (err_at == i);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_data = 8'h00; rx_error = (err_at == n);
        model_end(ref_good(n, len, err_at >= 0));
    endtask

    task automatic raw4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input int err_at);
        dg[0] = b0; dg[1] = b1; dg[2] = b2; dg[3] = b3;
        send(4, 4, err_at);
    endtask

    task automatic good4(input logic [7:0] op, input logic [7:0] arg);
        raw4(MAGIC, op, arg, MAGIC ^ op ^ arg, -1);
    endtask

    task automatic do_reset();
        idle(2);
        rst = 1'b1;
        model_reset();
        idle(3);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic rand_dg();
        int kind;
        int n;
        int len;
        int err_at;
        kind = int'($urandom_range(0, 9));
        n = 4; len = 4; err_at = -1;
        dg[0] = MAGIC;
        dg[1] = 8'($urandom_range(1, 6));
        dg[2] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        for (int i = 4; i < 8; i++) dg[i] = 8'($urandom);
        case (kind)
            1: dg[0] = dg[0] ^ (8'h01 << $urandom_range(0, 7));
            2: dg[1] = 8'($urandom);
            default: ;
        endcase
        dg[3] = dg[0] ^ dg[1] ^ dg[2];
        case (kind)
            0: dg[3] = dg[3] ^ (8'h01 << $urandom_range(0, 7));
            3: begin n = int'($urandom_range(1, 7)); len = n; end
            4: len = ($urandom_range(0, 1) == 0) ? 3 : int'($urandom_range(5, 65535));
            5: n = 5;
            6: err_at = int'($urandom_range(0, 4));
            default: ;
        endcase
        send(n, len, err_at);
        idle(int'($urandom_range(0, 2)));
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (done) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d expected responses never observed, want 0", exp_q.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
        mon_a.ok = cmd_ok; mon_a.cam = cfg_cam_sel; mon_a.wb = cfg_wb_en; mon_a.dw = cfg_dw_en;
        mon_a.se = cfg_send_en; mon_a.div = cfg_send_div; mon_a.op = cmd_op;
        mon_a.okc = ok_cnt; mon_a.errc = err_cnt;
        if (rst) begin
            checks++;
            if (mon_a !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0, 8'd0}) begin
                errors++;
                $display("FAIL reset_vals: got %h, want ok=0 cfg=0 div=01 op=00 cnts=0", mon_a);
            end
        end else if (pend) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL dg#%0d: datagram ended with no expected entry queued", dg_idx);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_a !== mon_e) begin
                    errors++;
                    $display("FAIL dg#%0d: got ok=%0b cam=%0b wb=%0b dw=%0b se=%0b div=%h op=%h okc=%0d errc=%0d; want ok=%0b cam=%0b wb=%0b dw=%0b se=%0b div=%h op=%h okc=%0d errc=%0d",
                             dg_idx, mon_a.ok, mon_a.cam, mon_a.wb, mon_a.dw, mon_a.se, mon_a.div, mon_a.op, mon_a.okc, mon_a.errc,
                             mon_e.ok, mon_e.cam, mon_e.wb, mon_e.dw, mon_e.se, mon_e.div, mon_e.op, mon_e.okc, mon_e.errc);
                end
            end
            dg_idx++;
        end else if (cmd_ok) begin
            checks++;
            errors++;
            $display("FAIL spurious_cmd_ok: got cmd_ok=1 outside E+1, want 0");
        end
        pend   = prev_v && !rx_valid && !rst;
        prev_v = rx_valid;
    end

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_data_len = 16'd0; rx_error = 1'b0;
        model_reset();
        idle(3);
        rst = 1'b0;
        idle(1);

        // first command selects cam2
        good4(8'h01, 8'h01);
        idle(2);

        // zero divider refused, then a valid divider
        do_reset();
        raw4(8'hA5, 8'h05, 8'h00, 8'hA0, -1);
        idle(1);
        raw4(8'hA5, 8'h05, 8'h10, 8'hB0, -1);
        idle(2);

        // checksum, magic, long and short datagrams
        do_reset();
        raw4(8'hA5, 8'h02, 8'h01, 8'h00, -1);
        idle(1);
        raw4(8'h5A, 8'h02, 8'h01, 8'h59, -1);
        idle(1);
        dg[0] = 8'hA5; dg[1] = 8'h02; dg[2] = 8'h01; dg[3] = 8'hA6; dg[4] = 8'h00;
        send(5, 5, -1);
        idle(1);
        send(3, 3, -1);
        idle(2);

        // engine error mid-datagram, then back-to-back good datagrams
        do_reset();
        raw4(8'hA5, 8'h02, 8'h01, 8'hA6, 2);
        idle(1);
        good4(8'h03, 8'h01);
        good4(8'h04, 8'h01);
        idle(2);

        // randomized mix
        for (int k = 0; k < 150; k++) rand_dg();
        idle(2);

        // error saturation, then restore defaults
        do_reset();
        good4(8'h01, 8'h01);
        good4(8'h02, 8'h01);
        good4(8'h03, 8'h01);
        good4(8'h04, 8'h01);
        good4(8'h05, 8'h37);
        for (int k = 0; k < 300; k++) begin
            raw4(MAGIC, 8'h02, 8'h01, 8'h00, -1);
        end
        good4(8'h06, 8'h5C);
        idle(2);

        // reset during B2, released while the stream is still running
        good4(8'h01, 8'h01);
        idle(2);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = 8'hA5; rx_data_len = 16'd4; rx_error = 1'b0;
        @(posedge clk); #1;
        rx_data = 8'h02;
        @(posedge clk); #1;
        rx_data = 8'h01; rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rx_data = 8'hA6; rst = 1'b0;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_data = 8'h00;
        model_end(1'b0);
        idle(1);
        good4(8'h02, 8'h01);
        idle(3);

        done = 1'b1;
        idle(5);
        $display("FAIL watchdog: monitor did not finish the run");
        $fatal(1);
    end

endmodule

// File: doc/udp_cmd_parser.md
# udp_cmd_parser

Receive-side command decoder placed directly downstream of the UDP packet engine's RX byte stream, in the RGMII clock domain. It parses fixed-format 4-byte control datagrams from the host PC, validates length, header and checksum, and commits the result to registered configuration outputs. Those outputs are camera select, white-balance enable, draw-box enable, send enable and send-rate divider. They replace the board push-button switches as the frame-process and sender controls. Malformed datagrams are dropped and counted; they never alter configuration.

## Interface
Parameters:
- MAGIC, 8'hA5, required value of byte 0
- DEF_CAM, 1'b0, reset value of cfg_cam_sel
- DEF_SEND_DIV, 8'd1, reset value of cfg_send_div

Ports:
- clk  in  1  RGMII RX-side user clock, 125 MHz
- rst  in  1  reset, asynchronous, active-high
- rx_valid  in  1  byte strobe; high for each payload byte, contiguous within one datagram
- rx_data  in  8  payload byte, valid when rx_valid=1
- rx_data_len  in  16  payload length of the current datagram, stable while rx_valid=1
- rx_error  in  1  engine-reported datagram error
- cfg_cam_sel  out  1  0=cam1, 1=cam2
- cfg_wb_en  out  1  white-balance enable
- cfg_dw_en  out  1  draw-box enable
- cfg_send_en  out  1  UDP line streaming enable
- cfg_send_div  out  8  send-trigger divider, never 0
- cmd_ok  out  1  one-cycle pulse per committed command
- cmd_op  out  8  opcode of the last committed command
- ok_cnt  out  8  committed commands, wraps at 255→0
- err_cnt  out  8  rejected datagrams, saturates at 255

## Operation
- Datagram format: B0=MAGIC, B1=opcode, B2=arg, B3=B0^B1^B2.
- A datagram starts on the first cycle rx_valid=1 after rx_valid=0. It ends on the first subsequent cycle with rx_valid=0, called cycle E.
- FSM states:
  - IDLE: wait for rx_valid.
  - HDR: the B0 cycle. Check rx_data_len==4 and rx_data==MAGIC.
  - OP: capture B1.
  - ARG: capture B2.
  - CHK: compare B3 with the running XOR.
  - WAIT_END: 4 bytes taken; any further byte sets the bad flag.
  - DROP: bad datagram; consume bytes until E.
- Any failed check, or rx_error=1 on any cycle from start through E, moves the FSM to DROP, or marks the datagram bad if already past CHK.
- At E the FSM always returns to IDLE:
  - Good datagram with a known opcode: commit it and increment ok_cnt.
  - Bad datagram or unknown opcode: increment err_cnt, saturating.
- A datagram shorter than 4 bytes (E reached in OP, ARG or CHK) is rejected.
- Opcodes:
  - 01: cfg_cam_sel=arg[0]
  - 02: cfg_wb_en=arg[0]
  - 03: cfg_dw_en=arg[0]
  - 04: cfg_send_en=arg[0]
  - 05: cfg_send_div=arg; arg=0 is rejected as an error
  - 06: restore all cfg_* to their reset values; arg is ignored
  - all others: rejected, cmd_op unchanged
- Reset values:
  - cfg_cam_sel=DEF_CAM, cfg_send_div=DEF_SEND_DIV
  - cfg_wb_en, cfg_dw_en, cfg_send_en = 0
  - cmd_ok, cmd_op, ok_cnt, err_cnt = 0
  - FSM = IDLE

## Timing
- All outputs are registered.
- Commit happens at the clock edge ending cycle E. cfg_*, cmd_op and ok_cnt show new values from E+1, and cmd_ok is high exactly during E+1. err_cnt updates with the same timing.
- Back-to-back datagrams separated by a single idle cycle: that cycle is E of the first datagram. A byte arriving in E+1 starts the next datagram, with no lost bytes.
- rst asserted mid-datagram: all outputs return to reset values immediately. After release the FSM is in IDLE. If rx_valid is already high at release, bytes are treated as DROP until rx_valid=0, so a datagram is never parsed from its middle.
- No backpressure: one byte per cycle is accepted unconditionally.

## Structure
- Package udp_cmd_pkg:
  - opcode localparams (OP_CAM=8'h01 … OP_DEFAULT=8'h06)
  - FSM state enum
  - CMD_LEN=16'd4
- Sub-module sat_counter (8-bit, increment enable, saturating/wrap mode parameter), instantiated for ok_cnt (wrap mode) and err_cnt (saturating mode).

## Test plan
- Reset, then send A5 01 01 A5 → cmd_ok pulses at E+1, cfg_cam_sel=1, cmd_op=01, ok_cnt=1, err_cnt=0.
- Send A5 05 00 A0, then A5 05 10 B0 → first rejected (err_cnt=1, cfg_send_div stays 1); second commits cfg_send_div=8'h10, ok_cnt=1.
- Bad checksum A5 02 01 00, bad magic 5A 02 01 59, 5-byte datagram, 3-byte datagram → each rejected, err_cnt=4, cfg_wb_en=0, no cmd_ok.
- Good datagram with rx_error pulsed during B2 → rejected, err_cnt=1. Then two good datagrams one idle cycle apart (opcodes 03, 04 with arg 01) → both commit, ok_cnt=2.
- 300 bad datagrams → err_cnt saturates at 255. Then opcode 06 → all cfg_* return to reset values.
- Assert rst during byte B2, release while rx_valid is still high → no commit, FSM drops the remainder. The next good datagram commits normally.
